bip_fetch_decode: RTL
=====================

Name: bip_fetch_decode

Overview:
Instruction fetch/decode controller for the BIP accumulator CPU. It is the initiator on the program-memory read interface: it drives the instruction address, captures the 16-bit word one cycle later, and decodes the 5-bit opcode and 11-bit operand into registered datapath control strobes. It sits between the program memory and the accumulator/ALU/data-RAM datapath, and owns the program counter and halt state.

Parameters:
NBITS_O, 11, instruction address width and operand width (PC width).
NBITS_D, 16, instruction word width.
NBITS_OPC, 5, opcode field width; NBITS_OPC + NBITS_O must equal NBITS_D.

Ports:
i_clk  in  1  clock; all logic is on posedge.
i_reset  in  1  synchronous reset, active-high; shared with program memory.
i_enable  in  1  run permission; when low, no new fetch is started.
o_Addr  out  NBITS_O  instruction address to program memory (current PC).
i_Data  in  NBITS_D  instruction word from program memory; valid one cycle after o_Addr is presented.
o_Operand  out  NBITS_O  operand field (i_Data[NBITS_O-1:0]) of the last decoded instruction.
o_WrAcc  out  1  accumulator write strobe.
o_WrRam  out  1  data-RAM write strobe (STO).
o_RdRam  out  1  data-RAM read strobe.
o_SelA  out  2  accumulator source: 00 RAM, 01 immediate, 10 ALU.
o_SelB  out  1  ALU B source: 0 RAM, 1 immediate.
o_Op  out  1  ALU operation: 0 add, 1 subtract.
o_Valid  out  1  one-cycle pulse: control outputs carry a decoded instruction.
o_Illegal  out  1  one-cycle pulse alongside o_Valid for an undefined opcode.
o_Halt  out  1  level; high while halted.

Behaviour:
- Opcodes: 00000 HLT, 00001 STO, 00010 LD, 00011 LDI, 00100 ADD, 00101 ADDI, 00110 SUB, 00111 SUBI. Codes 01000..11111 are illegal.
- Decode table (WrAcc, WrRam, RdRam, SelA, SelB, Op):
  - STO: 0,1,0,00,0,0
  - LD: 1,0,1,00,0,0
  - LDI: 1,0,0,01,0,0
  - ADD: 1,0,1,10,0,0
  - ADDI: 1,0,0,10,1,0
  - SUB: 1,0,1,10,0,1
  - SUBI: 1,0,0,10,1,1
  - HLT and illegal: all zero.
- FSM states:
  - FETCH: o_Addr = PC. Goes to EXEC if i_enable = 1; otherwise stays in FETCH.
  - EXEC: i_Data holds the word for PC. Decode it. On HLT go to HALT with PC unchanged. Otherwise PC <= PC+1 and go to FETCH. i_enable is ignored once EXEC is entered.
  - HALT: absorbing state; only i_reset exits it.
- Timing: control outputs are registered at the edge that ends EXEC. They, and o_Valid, are asserted for exactly the following cycle, which is the next FETCH. Otherwise all strobes are 0, and o_Operand holds its last value.
- Throughput: one instruction per 2 cycles. Latency from entering FETCH to o_Valid is 2 cycles.
- PC width is NBITS_O. PC wraps from 2^NBITS_O-1 to 0 with no flag.
- Illegal opcode: o_Valid=1, o_Illegal=1, all strobes 0 (executes as NOP). PC advances normally.
- HLT: o_Valid pulses with all strobes 0. o_Halt rises in the same cycle and stays high. o_Addr stays at the HLT address.
- Reset (any state, including mid-EXEC): PC=0, state=FETCH, and all outputs 0 (o_Operand=0, o_Halt=0).
  - Any pending decode is discarded; no strobe fires in the reset cycle or in the cycle after it.
  - Memory reinitialises under the same reset, so the first fetch after release reads the address-0 word without a wait state.

Decomposition:
- Package bip_pkg: opcode localparams (OPC_HLT..OPC_SUBI), SelA encodings (SELA_RAM/IMM/ALU), Op encodings, and FSM state encoding (FETCH, EXEC, HALT; 2 bits).
- Sub-module bip_instr_decoder: purely combinational opcode-to-controls table with an illegal flag. The parent registers its outputs and owns the PC and FSM.

Test Plan:
- Reset with memory word 0 = 0x1001 (LD 1), i_enable=1 -> o_Addr=0 in the first cycle; o_Valid, o_WrAcc and o_RdRam high in the 3rd cycle after release; o_SelA=00, o_Operand=0x001; o_Addr=1 during that cycle.
- Program LD 1, ADDI 2, STO 7, LDI 8, SUB 2, ADD 3, STO 8, LDI 3, LD 8, HLT -> o_Valid pulses every 2 cycles with the table values (e.g. ADDI: SelA=10, SelB=1, Op=0, Operand=0x002). On the HLT decode cycle o_Halt rises, o_Addr stays 9 and no further o_Valid pulses occur.
- Hold i_enable=0 for 5 cycles in FETCH at PC=3 -> no o_Valid pulse and o_Addr=3 throughout. Resume -> LDI 8 decoded 2 cycles later.
- Word 0xF800 (opcode 11111) at PC=0 -> o_Valid=1, o_Illegal=1, all strobes 0, next o_Addr=1.
- PC preloaded via a NOP-free stream to 0x7FF with a non-HLT word -> next o_Addr=0x000.
- Assert i_reset during EXEC of ADD 3 -> no o_WrAcc pulse, all outputs 0, o_Halt=0; execution restarts at address 0.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared encodings for the BIP fetch/decode controller: opcodes, datapath
// select codes, the decoded control bundle and the FSM state type.
package bip_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OPC_HLT  = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_STO  = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_LD   = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_SUBI = 5'b00111;

    // Accumulator source select
    localparam logic [1:0] SELA_RAM = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;

    // ALU B source select
    localparam logic SELB_RAM = 1'b0;
    localparam logic SELB_IMM = 1'b1;

    // ALU operation
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    // Datapath control strobes produced by one decoded instruction
    typedef struct packed {
        logic       wr_acc;
        logic       wr_ram;
        logic       rd_ram;
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
    } ctrl_t;

endpackage

// File: rtl/bip_instr_decoder.sv
// Combinational opcode-to-control table. HLT and undefined opcodes give an
// all-zero control bundle; undefined opcodes additionally raise illegal.
module bip_instr_decoder
    import bip_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output ctrl_t            ctrl,
    output logic             illegal
);

    // Table lookup; defaults keep every unlisted field at zero
    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        case (opcode)
            OPC_HLT: begin
            end
            OPC_STO: begin
                ctrl.wr_ram = 1'b1;
            end
            OPC_LD: begin
                ctrl.wr_acc = 1'b1;
                ctrl.rd_ram = 1'b1;
                ctrl.sel_a  = SELA_RAM;
            end
            OPC_LDI: begin
                ctrl.wr_acc = 1'b1;
                ctrl.sel_a  = SELA_IMM;
            end
            OPC_ADD: begin
                ctrl.wr_acc = 1'b1;
                ctrl.rd_ram = 1'b1;
                ctrl.sel_a  = SELA_ALU;
                ctrl.sel_b  = SELB_RAM;
                ctrl.op     = OP_ADD;
            end
            OPC_ADDI: begin
                ctrl.wr_acc = 1'b1;
                ctrl.sel_a  = SELA_ALU;
                ctrl.sel_b  = SELB_IMM;
                ctrl.op     = OP_ADD;
            end
            OPC_SUB: begin
                ctrl.wr_acc = 1'b1;
                ctrl.rd_ram = 1'b1;
                ctrl.sel_a  = SELA_ALU;
                ctrl.sel_b  = SELB_RAM;
                ctrl.op     = OP_SUB;
            end
            OPC_SUBI: begin
                ctrl.wr_acc = 1'b1;
                ctrl.sel_a  = SELA_ALU;
                ctrl.sel_b  = SELB_IMM;
                ctrl.op     = OP_SUB;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/bip_fetch_decode.sv
// BIP fetch/decode controller: owns the PC and the FETCH/EXEC/HALT FSM,
// reads program memory and registers the decoded control strobes.
//
// Program-memory read interface: there is no valid/ready pair. o_Addr is
// presented in FETCH and the memory returns the word on i_Data exactly one
// cycle later (during EXEC); the controller never stalls waiting for it.
// Downstream, o_Valid is a one-cycle pulse with no back-pressure: the
// datapath must consume the strobes in the cycle they are shown.
module bip_fetch_decode
    import bip_pkg::*;
#(
    parameter int NBITS_O   = 11,
    parameter int NBITS_D   = 16,
    parameter int NBITS_OPC = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    output logic [NBITS_O-1:0] o_Addr,
    input  logic [NBITS_D-1:0] i_Data,
    output logic [NBITS_O-1:0] o_Operand,
    output logic               o_WrAcc,
    output logic               o_WrRam,
    output logic               o_RdRam,
    output logic [1:0]         o_SelA,
    output logic               o_SelB,
    output logic               o_Op,
    output logic               o_Valid,
    output logic               o_Illegal,
    output logic               o_Halt,
    output state_t             dbg_state
);

    state_t               state;
    logic [NBITS_O-1:0]   pc;
    ctrl_t                ctrl_q;
    ctrl_t                dec_ctrl;
    logic                 dec_illegal;
    logic [NBITS_OPC-1:0] opcode;

    assign opcode = i_Data[NBITS_D-1 -: NBITS_OPC];

    bip_instr_decoder u_dec (
        .opcode  (opcode),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    // FSM, PC and registered decode outputs; strobes default to zero every
    // cycle so they only appear in the cycle right after EXEC
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= FETCH;
            pc        <= '0;
            ctrl_q    <= '0;
            o_Operand <= '0;
            o_Valid   <= 1'b0;
            o_Illegal <= 1'b0;
            o_Halt    <= 1'b0;
        end else begin
            ctrl_q    <= '0;
            o_Valid   <= 1'b0;
            o_Illegal <= 1'b0;
            case (state)
                FETCH: begin
                    if (i_enable) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    ctrl_q    <= dec_ctrl;
                    o_Operand <= i_Data[NBITS_O-1:0];
                    o_Valid   <= 1'b1;
                    o_Illegal <= dec_illegal;
                    if (opcode == OPC_HLT) begin
                        state  <= HALT;
                        o_Halt <= 1'b1;
                    end else begin
                        // PC wraps silently at the top of the address space
                        pc    <= pc + NBITS_O'(1);
                        state <= FETCH;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    assign o_Addr    = pc;
    assign o_WrAcc   = ctrl_q.wr_acc;
    assign o_WrRam   = ctrl_q.wr_ram;
    assign o_RdRam   = ctrl_q.rd_ram;
    assign o_SelA    = ctrl_q.sel_a;
    assign o_SelB    = ctrl_q.sel_b;
    assign o_Op      = ctrl_q.op;
    assign dbg_state = state;

endmodule
